// File: rtl/wb_async_sram_pkg.sv
// ============================================================================
// Module  : wb_async_sram_pkg
// Brief   : Shared types, counter width and cycle conversion for wb_async_sram.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_async_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int CNT_W = 8;

  // Whole clocks needed to cover ns at clk_hz, rounded up.
  function automatic int cycles(input int ns, input longint clk_hz);
    longint num;
    num = longint'(ns) * clk_hz + 64'sd999_999_999;
    return int'(num / 64'sd1_000_000_000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_async_sram_if.sv
// ============================================================================
// Module  : wb_async_sram_if
// Brief   : Wishbone pipelined slave bus plus asynchronous SRAM pin bundle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_async_sram_if #(
  parameter int AW = 16,
  parameter int DW = 16
) ();

  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata;
  logic [1:0]    wb_sel;
  logic          wb_stall;
  logic          wb_ack;
  logic [DW-1:0] wb_rdata;

  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          sram_lb_n;
  logic          sram_ub_n;
  logic          sram_drive;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
    output wb_stall, wb_ack, wb_rdata,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
    output sram_drive, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
    input  wb_stall, wb_ack, wb_rdata,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
    input  sram_drive, sram_addr, sram_wdata,
    output sram_rdata
  );

endinterface

`default_nettype wire

// File: rtl/wb_async_sram_cycle_timer.sv
// ============================================================================
// Module  : sram_cycle_timer
// Brief   : Down-counter that flags the final clock of a timed SRAM phase.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_cycle_timer
  import wb_async_sram_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         done
);

  logic [W-1:0] count;
  logic         running;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      count   <= load;
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) begin
        running <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign done = running && (count == '0);

endmodule

`default_nettype wire

// File: rtl/wb_async_sram.sv
// ============================================================================
// Module  : wb_async_sram
// Brief   : Wishbone pipelined slave driving a 12ns-class asynchronous SRAM.
//           SRAM_PIPE_READ_EN: back-to-back reads skip the idle turnaround.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_async_sram
  import wb_async_sram_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int RDCYCLES = cycles(12, 100_000_000),
  parameter int WRCYCLES = cycles(12, 100_000_000)
) (
  input  logic           i_clk,
  input  logic           i_reset,
  wb_async_sram_if.slave bus
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RDCYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRCYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic             idle_accept;
  logic             pipe_accept;
  logic             accept;
  logic             stall;
  logic             timer_done;
  logic [CNT_W-1:0] timer_load;

  logic             keep_ack;
  logic             ack;
  logic             ce_n;
  logic             oe_n;
  logic             we_n;
  logic             lb_n;
  logic             ub_n;
  logic             drive;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    wdata;
  logic [DW-1:0]    rdata;

  assign idle_accept = (state == IDLE) && bus.wb_cyc && bus.wb_stb;

`ifdef SRAM_PIPE_READ_EN
  assign pipe_accept = (state == READ) && timer_done && bus.wb_cyc
                       && bus.wb_stb && !bus.wb_we;
`else
  assign pipe_accept = 1'b0;
`endif

  sram_cycle_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk   (i_clk),
    .rst   (i_reset),
    .start (accept),
    .load  (timer_load),
    .done  (timer_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (idle_accept) next_state = bus.wb_we ? WRITE : READ;
      READ:    if (timer_done && !pipe_accept) next_state = IDLE;
      WRITE:   if (timer_done) next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stall      = (state != IDLE) && !pipe_accept;
    accept     = idle_accept || pipe_accept;
    timer_load = bus.wb_we ? WR_LOAD : RD_LOAD;
  end

  // Completion updates come first so a pipelined accept can override them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      keep_ack <= 1'b0;
      ack      <= 1'b0;
      ce_n     <= 1'b1;
      oe_n     <= 1'b1;
      we_n     <= 1'b1;
      lb_n     <= 1'b1;
      ub_n     <= 1'b1;
      drive    <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      rdata    <= '0;
    end else begin
      ack <= 1'b0;
      if ((state != IDLE) && !bus.wb_cyc) begin
        keep_ack <= 1'b0;
      end

      case (state)
        READ: begin
          if (timer_done) begin
            ce_n <= 1'b1;
            oe_n <= 1'b1;
            if (keep_ack && bus.wb_cyc) begin
              rdata <= bus.sram_rdata;
              ack   <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (timer_done) begin
            we_n <= 1'b1;
            ack  <= keep_ack && bus.wb_cyc;
          end
        end
        HOLD: begin
          ce_n  <= 1'b1;
          drive <= 1'b0;
        end
        default: ;
      endcase

      if (accept) begin
        keep_ack <= 1'b1;
        addr     <= bus.wb_addr;
        lb_n     <= !bus.wb_sel[0];
        ub_n     <= !bus.wb_sel[1];
        ce_n     <= 1'b0;
        if (bus.wb_we) begin
          wdata <= bus.wb_wdata;
          drive <= 1'b1;
          we_n  <= 1'b0;
          oe_n  <= 1'b1;
        end else begin
          drive <= 1'b0;
          we_n  <= 1'b1;
          oe_n  <= 1'b0;
        end
      end
    end
  end

  assign bus.wb_stall   = stall;
  assign bus.wb_ack     = ack;
  assign bus.wb_rdata   = rdata;
  assign bus.sram_ce_n  = ce_n;
  assign bus.sram_oe_n  = oe_n;
  assign bus.sram_we_n  = we_n;
  assign bus.sram_lb_n  = lb_n;
  assign bus.sram_ub_n  = ub_n;
  assign bus.sram_drive = drive;
  assign bus.sram_addr  = addr;
  assign bus.sram_wdata = wdata;

endmodule

`default_nettype wire

// File: tb/tb_wb_async_sram.sv
// ============================================================================
// Module  : tb_wb_async_sram
// Brief   : Directed self-checking bench for wb_async_sram with an SRAM model.
//           Expectations follow SRAM_PIPE_READ_EN when it is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_async_sram;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   bad_ovl;
  int   bad_drv;

  wb_async_sram_if #(.AW(16), .DW(16)) bus ();

  wb_async_sram #(
    .AW       (16),
    .DW       (16),
    .RDCYCLES (2),
    .WRCYCLES (2)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: unwritten words read as a fixed pattern.
  logic [15:0] mem [int];
  logic [15:0] wword;

  function automatic logic [15:0] peek(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return (a == 16'h1234) ? 16'hBEEF : ~a;
  endfunction

  always @(posedge clk) begin
    if (!rst && !bus.sram_ce_n && !bus.sram_we_n && bus.sram_drive) begin
      wword = peek(bus.sram_addr);
      if (!bus.sram_lb_n) wword[7:0]  = bus.sram_wdata[7:0];
      if (!bus.sram_ub_n) wword[15:8] = bus.sram_wdata[15:8];
      mem[int'(bus.sram_addr)] = wword;
    end
  end

  always @(negedge clk) begin
    bus.sram_rdata = (!bus.sram_ce_n && !bus.sram_oe_n) ? peek(bus.sram_addr) : 16'h0000;
    if (!bus.sram_oe_n && !bus.sram_we_n) bad_ovl++;
    if (bus.sram_drive && !bus.sram_oe_n) bad_drv++;
  end

  function automatic logic [7:0] pins();
    return {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_lb_n,
            bus.sram_ub_n, bus.sram_drive, bus.wb_stall, bus.wb_ack};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.wb_cyc   = 1'b0;
    bus.wb_stb   = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_wdata = '0;
    bus.wb_sel   = 2'b00;
  endtask

  task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] s);
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    bus.wb_we    = we;
    bus.wb_addr  = a;
    bus.wb_wdata = d;
    bus.wb_sel   = s;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d, output int lat);
    issue(1'b0, a, 16'h0000, 2'b11);
    tick();
    bus.wb_stb = 1'b0;
    lat = 0;
    d   = '0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.wb_ack) begin
        lat = k;
        d   = bus.wb_rdata;
        break;
      end
      tick();
    end
    bus_idle();
    tick();
  endtask

`ifdef SRAM_PIPE_READ_EN
  localparam int EXP_ACK1 = 5;
  localparam int EXP_ACK2 = 7;
  localparam int EXP_CEHI = 0;
`else
  localparam int EXP_ACK1 = 6;
  localparam int EXP_ACK2 = 9;
  localparam int EXP_CEHI = 2;
`endif

  logic [15:0] d;
  int          lat;
  logic        ackseen;
  int          req;
  logic        acc;
  int          nack;
  int          ce_hi;
  int          ack_cyc [3];
  logic [15:0] ack_dat [3];
  int          first_drv;
  logic [1:0]  ceoe3;

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    bad_ovl = 0;
    bad_drv = 0;
    rst     = 1'b1;
    bus_idle();
    repeat (3) tick();
    chk("reset_pins", pins(), 8'b11111000);
    chk("reset_rdata", bus.wb_rdata, 16'h0000);
    rst = 1'b0;
    tick();

    // Reset during a write pulse abandons it immediately.
    issue(1'b1, 16'h0030, 16'h1234, 2'b11);
    tick();
    bus.wb_stb = 1'b0;
    chk("rstmid_we_low", pins(), 8'b01000110);
    rst = 1'b1;
    tick();
    chk("rstmid_abandon", pins(), 8'b11111000);
    rst = 1'b0;
    bus_idle();
    tick();

    issue(1'b0, 16'h1234, 16'h0000, 2'b11);
    chk("rd_accept_stall", bus.wb_stall, 1'b0);
    tick();
    bus.wb_stb = 1'b0;
    chk("rd_c1_pins", pins(), 8'b00100010);
    chk("rd_c1_addr", bus.sram_addr, 16'h1234);
    tick();
    chk("rd_c2_pins", pins(), 8'b00100010);
    chk("rd_c2_addr", bus.sram_addr, 16'h1234);
    tick();
    chk("rd_c3_pins", pins(), 8'b11100001);
    chk("rd_c3_data", bus.wb_rdata, 16'hBEEF);
    tick();
    chk("rd_c4_ack", bus.wb_ack, 1'b0);
    bus_idle();

    issue(1'b1, 16'h0042, 16'hA55A, 2'b01);
    tick();
    bus.wb_stb = 1'b0;
    chk("wr_c1_pins", pins(), 8'b01001110);
    chk("wr_c1_addr_data", {bus.sram_addr, bus.sram_wdata}, 32'h0042_A55A);
    tick();
    chk("wr_c2_pins", pins(), 8'b01001110);
    tick();
    chk("wr_c3_hold_pins", pins(), 8'b01101111);
    chk("wr_c3_addr_data", {bus.sram_addr, bus.sram_wdata}, 32'h0042_A55A);
    tick();
    chk("wr_c4_idle_pins", pins(), 8'b11101000);
    bus_idle();
    rd(16'h0042, d, lat);
    chk("rd42_latency", lat, 3);
    chk("rd42_data", d, 16'hFF5A);

    // No byte lanes: the cycle still runs and acks, memory untouched.
    issue(1'b1, 16'h0060, 16'hFFFF, 2'b00);
    tick();
    bus.wb_stb = 1'b0;
    chk("wr_sel0_c1_pins", pins(), 8'b01011110);
    tick();
    tick();
    chk("wr_sel0_ack_pins", pins(), 8'b01111111);
    tick();
    bus_idle();
    rd(16'h0060, d, lat);
    chk("rd60_data", d, 16'hFF9F);

    // Bus cycle dropped right after a write is accepted.
    issue(1'b1, 16'h0050, 16'h1111, 2'b11);
    tick();
    bus_idle();
    chk("wr_abort_c1_pins", pins(), 8'b01000110);
    tick();
    chk("wr_abort_c2_pins", pins(), 8'b01000110);
    tick();
    chk("wr_abort_c3_pins", pins(), 8'b01100110);
    tick();
    chk("wr_abort_c4_pins", pins(), 8'b11100000);

    issue(1'b0, 16'h1234, 16'h0000, 2'b11);
    tick();
    bus_idle();
    ackseen = 1'b0;
    repeat (4) begin
      ackseen = ackseen | bus.wb_ack;
      tick();
    end
    chk("rd_abort_no_ack", ackseen, 1'b0);
    chk("rd_abort_rdata_hold", bus.wb_rdata, 16'hFF9F);
    rd(16'h0050, d, lat);
    chk("rd50_after_abort_wr", d, 16'h1111);

    // Three reads presented back to back.
    req   = 0;
    nack  = 0;
    ce_hi = 0;
    bus.wb_cyc = 1'b1;
    bus.wb_sel = 2'b11;
    for (int c = 0; c < 14; c++) begin
      bus.wb_stb  = (req < 3);
      bus.wb_we   = 1'b0;
      bus.wb_addr = 16'h0010 + 16'(req);
      @(negedge clk);
      if (bus.wb_ack && nack < 3) begin
        ack_cyc[nack] = c;
        ack_dat[nack] = bus.wb_rdata;
        nack++;
      end
      if (nack < 3 && c >= 1 && bus.sram_ce_n) ce_hi++;
      acc = bus.wb_stb && !bus.wb_stall;
      tick();
      if (acc) req++;
    end
    bus_idle();
    chk("burst_ack_count", nack, 3);
    chk("burst_ack0_cycle", ack_cyc[0], 3);
    chk("burst_ack1_cycle", ack_cyc[1], EXP_ACK1);
    chk("burst_ack2_cycle", ack_cyc[2], EXP_ACK2);
    chk("burst_data", {ack_dat[0], ack_dat[1]}, 32'hFFEF_FFEE);
    chk("burst_data2", ack_dat[2], 16'hFFED);
    chk("burst_ce_high_clocks", ce_hi, EXP_CEHI);
    tick();

    // Read followed immediately by a write: bus turnaround.
    req       = 0;
    first_drv = -1;
    ceoe3     = 2'b00;
    bus.wb_cyc = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.wb_stb   = (req < 2);
      bus.wb_we    = (req == 1);
      bus.wb_addr  = (req == 0) ? 16'h0020 : 16'h0021;
      bus.wb_wdata = 16'h7777;
      bus.wb_sel   = 2'b11;
      @(negedge clk);
      if (bus.sram_drive && first_drv < 0) first_drv = c;
      if (c == 3) ceoe3 = {bus.sram_ce_n, bus.sram_oe_n};
      acc = bus.wb_stb && !bus.wb_stall;
      tick();
      if (acc) req++;
    end
    bus_idle();
    tick();
    chk("turn_first_drive_cycle", first_drv, 4);
    chk("turn_idle_ce_oe", ceoe3, 2'b11);
    rd(16'h0021, d, lat);
    chk("rd21_data", d, 16'h7777);

    chk("oe_we_overlap_clocks", bad_ovl, 0);
    chk("drive_with_oe_clocks", bad_drv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
